// File: rtl/hc595_driver.sv
// Serialises a {seg, sel} frame into a 74HC595 pair: 14 bits MSB-first on ds/shcp, then an stcp latch pulse.
// Optional macro HC595_OE_BLANK_EN blanks the display (oe=1) during every storage update.
module hc595_driver #(
  parameter logic [7:0] SHCP_HALF = 8'd2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] sel,
  input  logic [7:0] seg,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic       shcp,
  output logic       stcp,
  output logic       ds,
  output logic       oe
);

  localparam int unsigned FRAME_W     = 14;
  localparam logic [3:0]  LAST_BIT    = 4'd13;
  localparam logic [7:0]  HALF_RELOAD = SHCP_HALF - 8'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           hcnt_q, hcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 shcp_q, shcp_d;
  logic                 stcp_q, stcp_d;
  logic                 ds_q, ds_d;
  logic                 oe_q, oe_d;

  // Next-state and next-output computation; every output below is registered.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shcp_d  = shcp_q;
    stcp_d  = stcp_q;
    ds_d    = ds_q;
    oe_d    = oe_q;

    case (state_q)
      IDLE: begin
        shcp_d = 1'b0;
        stcp_d = 1'b0;
        busy_d = 1'b0;
        if (load) begin
          frame_d = {seg, sel};
          ds_d    = seg[7];
          hcnt_d  = HALF_RELOAD;
          bcnt_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d = HALF_RELOAD;
          if (!shcp_q) begin
            shcp_d = 1'b1;
          end else begin
            // End of a bit slot: shcp falls and ds advances in the same cycle.
            shcp_d = 1'b0;
            if (bcnt_q == LAST_BIT) begin
              bcnt_d  = 4'd0;
              stcp_d  = 1'b1;
              state_d = LATCH;
`ifdef HC595_OE_BLANK_EN
              oe_d    = 1'b1;
`else
              oe_d    = 1'b0;
`endif
            end else begin
              bcnt_d = bcnt_q + 4'd1;
              ds_d   = frame_q[4'd12 - bcnt_q];
            end
          end
        end
      end

      LATCH: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d  = 8'd0;
          stcp_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef HC595_OE_BLANK_EN
          oe_d    = 1'b0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        shcp_d  = 1'b0;
        stcp_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= 8'd0;
      bcnt_q  <= 4'd0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      ds_q    <= 1'b0;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      ds_q    <= ds_d;
      oe_q    <= oe_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign ds   = ds_q;
  assign oe   = oe_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: two instances (SHCP_HALF=2 and 1) checked every cycle against a timeline model.
module tb_hc595_driver;

  localparam int HA = 2;
  localparam int HB = 1;
`ifdef HC595_OE_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] sel_s  [2];
  logic [7:0] seg_s  [2];
  logic       load_s [2];
  logic       busy_s [2];
  logic       done_s [2];
  logic       shcp_s [2];
  logic       stcp_s [2];
  logic       ds_s   [2];
  logic       oe_s   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hc595_driver #(.SHCP_HALF(8'(HA))) u_dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .sel(sel_s[0]), .seg(seg_s[0]), .load(load_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .shcp(shcp_s[0]), .stcp(stcp_s[0]), .ds(ds_s[0]), .oe(oe_s[0])
  );

  hc595_driver #(.SHCP_HALF(8'(HB))) u_dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .sel(sel_s[1]), .seg(seg_s[1]), .load(load_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .shcp(shcp_s[1]), .stcp(stcp_s[1]), .ds(ds_s[1]), .oe(oe_s[1])
  );

  // Model state: t counts cycles since the first busy cycle of the current frame.
  typedef struct packed {
    logic        act;
    int          t;
    logic [13:0] frm;
    logic        done;
    logic        ds;
    logic        latched;
  } mdl_t;

  mdl_t mdl [2];

  function automatic mdl_t step(input mdl_t m, input int h, input logic ld, input logic [13:0] fin);
    mdl_t       r;
    logic [3:0] bi;
    r      = m;
    r.done = 1'b0;
    if (r.act) begin
      r.t = r.t + 1;
      if (r.t == 29 * h) begin
        r.act  = 1'b0;
        r.done = 1'b1;
      end
    end else if (ld) begin
      r.act = 1'b1;
      r.t   = 0;
      r.frm = fin;
    end
    if (r.act) begin
      if (r.t < 28 * h) begin
        bi   = 4'(13 - r.t / (2 * h));
        r.ds = r.frm[bi];
      end else begin
        r.ds      = r.frm[0];
        r.latched = 1'b1;
      end
    end
    return r;
  endfunction

  // Expected {busy, done, shcp, stcp, ds, oe} for the current cycle.
  function automatic logic [5:0] expo(input mdl_t m, input int h);
    logic sh, st, o;
    sh = m.act && (m.t < 28 * h) && ((m.t % (2 * h)) >= h);
    st = m.act && (m.t >= 28 * h);
    o  = BLANK ? (!m.latched || st) : !m.latched;
    return {m.act, m.done, sh, st, m.ds, o};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= '0;
      mdl[1] <= '0;
    end else begin
      mdl[0] <= step(mdl[0], HA, load_s[0], {seg_s[0], sel_s[0]});
      mdl[1] <= step(mdl[1], HB, load_s[1], {seg_s[1], sel_s[1]});
    end
  end

  task automatic chk(input string nm, input int w, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%0d required=%0d", nm, w, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int w);
    logic [5:0] e;
    e = expo(mdl[w], (w == 0) ? HA : HB);
    chk("busy", w, int'(busy_s[w]), int'(e[5]));
    chk("done", w, int'(done_s[w]), int'(e[4]));
    chk("shcp", w, int'(shcp_s[w]), int'(e[3]));
    chk("stcp", w, int'(stcp_s[w]), int'(e[2]));
    chk("ds",   w, int'(ds_s[w]),   int'(e[1]));
    chk("oe",   w, int'(oe_s[w]),   int'(e[0]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0);
    cmp_inst(1);
  end

  // One frame with literal expectations on length, serial content, latch width and oe.
  task automatic run_frame(input int w, input logic [7:0] sg, input logic [5:0] sl,
                           input bit poke, input bit first);
    int          h;
    int          nb, ns, nd, noe, nbits;
    logic [13:0] got;
    logic        pshcp;
    h = (w == 0) ? HA : HB;
    nb = 0; ns = 0; nd = 0; noe = 0; nbits = 0;
    got = '0;
    pshcp = 1'b0;
    seg_s[w]  = sg;
    sel_s[w]  = sl;
    load_s[w] = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      load_s[w] = (poke && i == 10) ? 1'b1 : 1'b0;
      seg_s[w]  = 8'($urandom);
      sel_s[w]  = 6'($urandom);
      if (busy_s[w]) nb++;
      if (stcp_s[w]) ns++;
      if (done_s[w]) nd++;
      if (busy_s[w] && oe_s[w]) noe++;
      if (shcp_s[w] && !pshcp) begin
        got = {got[12:0], ds_s[w]};
        nbits++;
      end
      pshcp = shcp_s[w];
    end
    chk("frame_busy_len", w, nb, 29 * h);
    chk("frame_stcp_width", w, ns, h);
    chk("frame_done_count", w, nd, 1);
    chk("frame_bit_count", w, nbits, 14);
    chk("frame_serial_data", w, int'(got), int'({sg, sl}));
    chk("frame_oe_high_busy", w, noe, first ? (BLANK ? 29 * h : 28 * h) : (BLANK ? h : 0));
    chk("frame_oe_after", w, int'(oe_s[w]), 0);
  endtask

  initial begin
    int          last;
    int          nd;
    logic [13:0] lit;
    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      sel_s[w] = '0; seg_s[w] = '0; load_s[w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, int'(busy_s[0]), 0);
    chk("rst_done", 0, int'(done_s[0]), 0);
    chk("rst_shcp", 0, int'(shcp_s[0]), 0);
    chk("rst_stcp", 0, int'(stcp_s[0]), 0);
    chk("rst_ds",   0, int'(ds_s[0]),   0);
    chk("rst_oe",   0, int'(oe_s[0]),   1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference frame seg=C0, sel=111110 -> serial 1,1,0,0,0,0,0,0,1,1,1,1,1,0.
    lit = 14'b11000000111110;
    chk("lit_frame_bits", 0, int'({8'hC0, 6'b111110}), int'(lit));
    run_frame(0, 8'hC0, 6'b111110, 1'b0, 1'b1);
    run_frame(1, 8'hC0, 6'b111110, 1'b0, 1'b1);

    // Mid-frame load request and input changes must not disturb the captured frame.
    run_frame(0, 8'($urandom), 6'($urandom), 1'b1, 1'b0);

    // load held high: back-to-back frames every 59 cycles.
    last = -1;
    nd   = 0;
    load_s[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seg_s[0] = 8'($urandom);
      sel_s[0] = 6'($urandom);
      if (done_s[0]) begin
        if (last >= 0) chk("held_period", 0, i - last, 59);
        chk("held_done_busy", 0, int'(busy_s[0]), 0);
        last = i;
        nd++;
      end
    end
    load_s[0] = 1'b0;
    chk("held_done_count", 0, nd, 3);
    repeat (70) @(negedge clk);
    chk("held_idle_after", 0, int'(busy_s[0]), 0);

    // Reset during bit 7 of a frame.
    seg_s[0]  = 8'($urandom);
    sel_s[0]  = 6'($urandom);
    load_s[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      load_s[0] = 1'b0;
    end
    chk("pre_rst_busy", 0, int'(busy_s[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 0, int'(busy_s[0]), 0);
    chk("mid_rst_done", 0, int'(done_s[0]), 0);
    chk("mid_rst_shcp", 0, int'(shcp_s[0]), 0);
    chk("mid_rst_stcp", 0, int'(stcp_s[0]), 0);
    chk("mid_rst_ds",   0, int'(ds_s[0]),   0);
    chk("mid_rst_oe",   0, int'(oe_s[0]),   1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_stcp", 0, int'(stcp_s[0]), 0);
      chk("post_rst_oe", 0, int'(oe_s[0]), 1);
    end
    run_frame(0, 8'($urandom), 6'($urandom), 1'b0, 1'b1);
    run_frame(0, 8'($urandom), 6'($urandom), 1'b0, 1'b0);

    // Random traffic on both instances with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        seg_s[w]  = 8'($urandom);
        sel_s[w]  = 6'($urandom);
        load_s[w] = ($urandom_range(0, (w == 0) ? 7 : 3) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    load_s[0] = 1'b0;
    load_s[1] = 1'b0;
    repeat (70) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc595_driver.md
HC595_DRIVER -- requirements
Module: hc595_driver

Interface
REQ-001 Parameter SHCP_HALF, default 8'd2, sys_clk cycles per half shcp period; legal range 1..255.
REQ-002 sys_clk  input  1  system clock; all logic on its rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 sel  input  6  digit-select pattern from the dynamic-scan stage, active-low per digit.
REQ-005 seg  input  8  segment pattern {dp,g,f,e,d,c,b,a} from the dynamic-scan stage, active-low per segment.
REQ-006 load  input  1  frame-start request; sampled every cycle.
REQ-007 busy  output  1  high while a frame is being shifted or latched.
REQ-008 done  output  1  one-cycle pulse marking completion of a frame.
REQ-009 shcp  output  1  74HC595 shift clock.
REQ-010 stcp  output  1  74HC595 storage (latch) clock.
REQ-011 ds  output  1  74HC595 serial data.
REQ-012 oe  output  1  74HC595 output enable, active-low.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, LATCH.
REQ-014 In IDLE, load=1 SHALL capture frame[13:0] = {seg[7:0], sel[5:0]} and enter SHIFT on the next cycle.
REQ-015 load SHALL be ignored while busy=1; seg/sel changes after capture SHALL NOT affect the current frame.
REQ-016 SHIFT SHALL send 14 bits, frame[13] first and frame[0] last.
REQ-017 Each bit slot SHALL last 2*SHCP_HALF cycles: ds holds the bit for the whole slot, shcp=0 for the first SHCP_HALF cycles and shcp=1 for the second SHCP_HALF cycles.
REQ-018 ds SHALL change only in the cycle when shcp falls to 0, never while shcp=1.
REQ-019 After bit 14, the FSM SHALL enter LATCH, with shcp=0 and stcp=1 for SHCP_HALF cycles, then return to IDLE.
REQ-020 busy SHALL be 1 from the first SHIFT cycle through the last LATCH cycle; total busy length is 29*SHCP_HALF cycles.
REQ-021 done SHALL be 1 for exactly the first IDLE cycle after LATCH, with busy=0 in that cycle.
REQ-022 load=1 in the done cycle SHALL be accepted, giving back-to-back frames with one idle cycle between them.
REQ-023 In IDLE, shcp=0, stcp=0, and ds SHALL hold its last value.
REQ-024 The half-period counter is 8 bits and the bit counter is 4 bits (0..13).
REQ-025 Both counters SHALL reload at every phase boundary, with no wrap beyond their terminal values.
REQ-026 oe SHALL go to 0 in the cycle stcp first rises after reset and SHALL stay 0 thereafter (subject to REQ-031).

Reset
REQ-027 sys_rst_n=0 SHALL asynchronously force: state=IDLE, busy=0, done=0, shcp=0, stcp=0, ds=0, oe=1, counters=0, frame=0.
REQ-028 Reset asserted mid-SHIFT or mid-LATCH SHALL discard the frame, with no stcp pulse issued.
REQ-029 After reset, oe SHALL stay 1 until a complete frame has been latched.

Configuration
REQ-030 Macro HC595_OE_BLANK_EN SHALL select the oe blanking behaviour.
REQ-031 With HC595_OE_BLANK_EN defined, oe SHALL be 1 for every LATCH cycle and 0 otherwise (after the first latch), blanking the display during storage update to suppress digit ghosting.
REQ-032 Without HC595_OE_BLANK_EN, oe SHALL follow REQ-026 only, with no blanking and no added logic.

Verification (SHCP_HALF=2)
REQ-033 Reset release, then seg=8'hC0, sel=6'b111110, load pulse -> busy high for 58 cycles; ds serial sequence 1,1,0,0,0,0,0,0,1,1,1,1,1,0 sampled on shcp rising edges; one stcp pulse 2 cycles wide; done pulse; oe falls to 0.
REQ-034 load held high for 200 cycles -> frames repeat every 59 cycles; exactly one done pulse per frame.
REQ-035 load pulsed at SHIFT cycle 10, and seg/sel changed mid-frame -> no restart; shifted data equals the originally captured frame.
REQ-036 sys_rst_n pulsed low during bit 7 -> all outputs take their reset values immediately; no stcp pulse; oe=1 until the next full frame.
REQ-037 With HC595_OE_BLANK_EN defined, two back-to-back frames -> oe=1 exactly during each 2-cycle LATCH and 0 in all other cycles after the first latch; without the macro, oe stays 0.
REQ-038 SHCP_HALF=1, a single frame -> busy=29 cycles; shcp toggles every cycle; ds stable across each shcp high phase.
